// File: rtl/word_arb_pkg.sv
// -----------------------------------------------------------------------------
// word_arb_pkg
// Shared types and constants for the two-requester word bus arbiter.
//   WORD_W       default data word width
//   arb_state_t  arbiter state: IDLE (nothing held) / HOLD (word on output)
//   SRC_A/SRC_B  encoding of the word owner reported on out_src
//   pick_src     round-robin winner selection between the two requesters
// -----------------------------------------------------------------------------
package word_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // A lone requester always wins; on a tie the requester that was not served
  // last wins, which gives strict A,B,A,B alternation under constant load.
  function automatic logic pick_src(input logic req_a,
                                    input logic req_b,
                                    input logic last_src);
    if (req_a && req_b) begin
      return ~last_src;
    end else if (req_b) begin
      return SRC_B;
    end else begin
      return SRC_A;
    end
  endfunction

endpackage

// File: rtl/word_mux2.sv
// -----------------------------------------------------------------------------
// word_mux2
// Purely combinational WIDTH-bit 2:1 word multiplexer.
// Ports:
//   in0  word selected when sel = 0
//   in1  word selected when sel = 1
//   sel  select
//   out  selected word
// -----------------------------------------------------------------------------
module word_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/word_bus_arbiter.sv
// -----------------------------------------------------------------------------
// word_bus_arbiter
// Round-robin arbiter for two requesters sharing one registered word output.
// In IDLE the winner's word is captured into the output register; in HOLD the
// word is frozen until the consumer takes it (out_valid & out_ready), at which
// point the owner gets a one-cycle combinational ack and the arbiter returns
// to IDLE. Re-arbitration only happens in IDLE, so a requester still showing
// req during its ack cycle is never granted twice for the same word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_a/word_a        requester A request and data (stable while req_a)
//   req_b/word_b        requester B request and data (stable while req_b)
//   ack_a/ack_b         one-cycle pulse: that requester's word was taken
//   out_valid/out_ready consumer handshake
//   out_word            registered selected word
//   out_src             owner of out_word (SRC_A = 0, SRC_B = 1)
//   grant_cnt_a/_b      saturating ack counters, only when ARB_STATS_EN is
//                       defined
//
// Build option: define ARB_STATS_EN to add the grant counters.
// -----------------------------------------------------------------------------
module word_bus_arbiter
  import word_arb_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] word_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] word_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt_a,
  output logic [CNT_W-1:0] grant_cnt_b,
`endif
  output logic [WIDTH-1:0] out_word,
  output logic             out_src
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("word_bus_arbiter: CNT_W must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic             sel;
  logic [WIDTH-1:0] mux_word;
  logic             transfer;

  assign sel = pick_src(req_a, req_b, last_q);

  word_mux2 #(
    .WIDTH(WIDTH)
  ) u_word_mux (
    .in0 (word_a),
    .in1 (word_b),
    .sel (sel),
    .out (mux_word)
  );

  assign out_valid = (state_q == HOLD);
  assign transfer  = out_valid & out_ready;
  assign ack_a     = transfer & (src_q == SRC_A);
  assign ack_b     = transfer & (src_q == SRC_B);
  assign out_word  = word_q;
  assign out_src   = src_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    src_d   = src_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = HOLD;
          word_d  = mux_word;
          src_d   = sel;
          last_d  = sel;
        end
      end
      HOLD: begin
        // Word and owner stay frozen; only the handshake moves us on.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      src_q   <= SRC_A;
      last_q  <= SRC_B;  // A wins the first tie after reset
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (ack_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (ack_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + CNT_W'(1);
    end
  end

  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_word_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_word_bus_arbiter
// Directed bench for word_bus_arbiter. A transaction-level model (held word,
// owner, last winner, ack counts) predicts the outputs; a negedge process
// compares them every cycle, and directed literal checks pin the model.
// With ARB_STATS_EN a second instance with CNT_W=2 checks saturation.
// -----------------------------------------------------------------------------
module tb_word_bus_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  word_a = '0, word_b = '0;
  logic          ack_a, ack_b, out_valid, out_src;
  logic [W-1:0]  out_word;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b;
  logic        s_ack_a, s_ack_b, s_out_valid, s_out_src;
  logic [W-1:0] s_out_word;
  logic [1:0]  s_cnt_a, s_cnt_b;
`endif

  word_bus_arbiter #(.WIDTH(W), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .word_a     (word_a),
    .req_b      (req_b),
    .word_b     (word_b),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef ARB_STATS_EN
    .grant_cnt_a(grant_cnt_a),
    .grant_cnt_b(grant_cnt_b),
`endif
    .out_word   (out_word),
    .out_src    (out_src)
  );

`ifdef ARB_STATS_EN
  word_bus_arbiter #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .word_a     (word_a),
    .req_b      (req_b),
    .word_b     (word_b),
    .ack_a      (s_ack_a),
    .ack_b      (s_ack_b),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .grant_cnt_a(s_cnt_a),
    .grant_cnt_b(s_cnt_b),
    .out_word   (s_out_word),
    .out_src    (s_out_src)
  );
`endif

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit         m_held = 1'b0;
  logic [W-1:0] m_word = '0;
  bit         m_src  = 1'b0;
  bit         m_last = 1'b1;
  int         m_cnt_a = 0, m_cnt_b = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held = 1'b0; m_word = '0; m_src = 1'b0; m_last = 1'b1;
      m_cnt_a = 0;   m_cnt_b = 0;
    end else if (m_held) begin
      if (out_ready) begin
        m_held = 1'b0;
        if (m_src) m_cnt_b++; else m_cnt_a++;
      end
    end else if (req_a || req_b) begin
      m_src  = (req_a && req_b) ? !m_last : req_b;
      m_word = m_src ? word_b : word_a;
      m_last = m_src;
      m_held = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_valid", out_valid, m_held);
      check("cmp_ack_a", ack_a, m_held && out_ready && !m_src);
      check("cmp_ack_b", ack_b, m_held && out_ready && m_src);
      if (m_held) begin
        check("cmp_word", out_word, m_word);
        check("cmp_src",  out_src,  m_src);
      end
`ifdef ARB_STATS_EN
      check("cmp_cnt_a", grant_cnt_a, m_cnt_a);
      check("cmp_cnt_b", grant_cnt_b, m_cnt_b);
      check("cmp_sat_a", s_cnt_a, (m_cnt_a > 3) ? 3 : m_cnt_a);
      check("cmp_sat_b", s_cnt_b, (m_cnt_b > 3) ? 3 : m_cnt_b);
`endif
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_seq [4];

  initial begin
    rst_n = 1'b0;
    tick(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_word",  out_word,  32'h0);
    check("rst_src",   out_src,   1'b0);
    check("rst_ack",   {ack_a, ack_b}, 2'b00);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single A request: valid one edge later, ack in that cycle.
    req_a = 1'b1; word_a = 32'h0000_00A5; out_ready = 1'b1;
    tick();
    check("t1_valid", out_valid, 1'b1);
    check("t1_word",  out_word,  32'h0000_00A5);
    check("t1_src",   out_src,   1'b0);
    check("t1_ack_a", ack_a,     1'b1);
    tick();
    req_a = 1'b0;
    check("t1_idle",  out_valid, 1'b0);
    check("t1_noack", ack_a,     1'b0);
    tick();
    check("t1_stay_idle", out_valid, 1'b0);

    // Both requesting continuously: A,B,A,B.
    do_reset();
    req_a = 1'b1; word_a = 32'h1111_1111;
    req_b = 1'b1; word_b = 32'h2222_2222;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid && out_ready) got_q.push_back(out_word);
    end
    req_a = 1'b0; req_b = 1'b0;
    exp_seq[0] = 32'h1111_1111; exp_seq[1] = 32'h2222_2222;
    exp_seq[2] = 32'h1111_1111; exp_seq[3] = 32'h2222_2222;
    check("t2_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check($sformatf("t2_word%0d", i), got_q[i], exp_seq[i]);
    end
    tick();

    // B held under back-pressure while its input word changes.
    req_b = 1'b1; word_b = 32'h3333_3333; out_ready = 1'b0;
    tick();
    word_b = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("t3_frozen", out_word, 32'h3333_3333);
      check("t3_no_ack", ack_b, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t3_ack_b", ack_b, 1'b1);
    check("t3_src",   out_src, 1'b1);
    tick();
    req_b = 1'b0;
    tick();

    // Reset mid-HOLD drops the word; the still-pending req is re-served.
    req_a = 1'b1; word_a = 32'h4444_4444; out_ready = 1'b0;
    tick();
    check("t4_hold", out_valid, 1'b1);
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    check("t4_rst_valid", out_valid, 1'b0);
    check("t4_rst_word",  out_word,  32'h0);
    check("t4_rst_ack",   {ack_a, ack_b}, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_reserve_word", out_word, 32'h4444_4444);
    check("t4_reserve_ack",  ack_a, 1'b1);
    tick();
    req_a = 1'b0;
    tick();

`ifdef ARB_STATS_EN
    // 3 A transfers then 2 B transfers.
    do_reset();
    out_ready = 1'b1;
    req_a = 1'b1; word_a = 32'h5555_5555;
    tick(6);
    req_a = 1'b0; req_b = 1'b1; word_b = 32'h6666_6666;
    tick(4);
    req_b = 1'b0;
    tick();
    check("st_cnt_a", grant_cnt_a, 3);
    check("st_cnt_b", grant_cnt_b, 2);
    // 5 A transfers saturate the 2-bit counter at 3.
    do_reset();
    req_a = 1'b1;
    tick(10);
    req_a = 1'b0;
    tick();
    check("st_cnt_a5", grant_cnt_a, 5);
    check("st_sat_a",  s_cnt_a,     3);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
